// File: rtl/cnn_acc_ci_sched.sv
// cnn_acc_ci_sched: sequences one shared CI-accumulator datapath across CO
// output channels for each accepted input window. It collects each channel
// sum into a packed buffer and presents that buffer downstream.
//
// Handshakes:
//   i_win_valid/o_win_ready: a window is accepted on a clock edge where both
//   are high. o_win_ready is high only in IDLE.
//   o_ot_valid/i_ot_ready: the result is consumed on a clock edge where both
//   are high. o_ot_valid and o_ot_data hold steady until that edge.
//   o_acc_in_valid is a one-cycle start pulse with no ready. The datapath
//   answers with a single-cycle i_acc_valid some cycles later.
//
// A watchdog bounds the time spent waiting for each channel. When it
// expires, the datapath gets a one-cycle soft reset and the same channel is
// issued again.
module cnn_acc_ci_sched #(
    parameter int CO        = 3,
    parameter int ACC_BW    = 24,
    parameter int CO_IDX_BW = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_soft_reset,
    input  logic                   i_win_valid,
    output logic                   o_win_ready,
    output logic [CO_IDX_BW-1:0]   o_w_sel,
    output logic                   o_acc_in_valid,
    output logic                   o_acc_soft_reset,
    input  logic                   i_acc_valid,
    input  logic [ACC_BW-1:0]      i_acc_data,
    input  logic                   i_ot_ready,
    output logic                   o_ot_valid,
    output logic [CO*ACC_BW-1:0]   o_ot_data,
    output logic                   o_busy,
    output logic                   o_err
);

    localparam int WD_BW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CO_IDX_BW-1:0]   r_co;
    logic [WD_BW-1:0]       r_wd_cnt;
    logic [CO*ACC_BW-1:0]   r_buf;
    logic                   r_err;
    logic                   r_wd_pulse;
    logic                   r_acc_in_valid;
    logic                   r_ot_valid;
    logic                   r_win_ready;
    logic                   r_busy;

    // Watchdog expiry: this WAIT cycle would bring the count to TIMEOUT
    // without a result. A result arriving in the same cycle takes priority.
    logic w_wd_fire;
    assign w_wd_fire = (r_state == S_WAIT) && !i_acc_valid
                       && (r_wd_cnt == WD_BW'(TIMEOUT - 1));

    // This cycle's result belongs to the last channel of the window.
    logic w_last_ch;
    assign w_last_ch = (r_co == CO_IDX_BW'(CO - 1));

    // Scheduler FSM. All of its outputs are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_co           <= '0;
            r_wd_cnt       <= '0;
            r_buf          <= '0;
            r_err          <= 1'b0;
            r_wd_pulse     <= 1'b0;
            r_acc_in_valid <= 1'b0;
            r_ot_valid     <= 1'b0;
            r_win_ready    <= 1'b1;
            r_busy         <= 1'b0;
        end else if (i_soft_reset) begin
            r_state        <= S_IDLE;
            r_co           <= '0;
            r_wd_cnt       <= '0;
            r_buf          <= '0;
            r_err          <= 1'b0;
            r_wd_pulse     <= 1'b0;
            r_acc_in_valid <= 1'b0;
            r_ot_valid     <= 1'b0;
            r_win_ready    <= 1'b1;
            r_busy         <= 1'b0;
        end else begin
            r_wd_pulse     <= 1'b0;
            r_acc_in_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_win_valid) begin
                        r_co           <= '0;
                        r_state        <= S_ISSUE;
                        r_acc_in_valid <= 1'b1;
                        r_win_ready    <= 1'b0;
                        r_busy         <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_wd_cnt <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wd_cnt != WD_BW'(TIMEOUT))
                        r_wd_cnt <= r_wd_cnt + WD_BW'(1);
                    if (i_acc_valid) begin
                        for (int c = 0; c < CO; c++) begin
                            if (r_co == CO_IDX_BW'(c))
                                r_buf[c*ACC_BW +: ACC_BW] <= i_acc_data;
                        end
                        if (w_last_ch) begin
                            r_state    <= S_OUT;
                            r_ot_valid <= 1'b1;
                        end else begin
                            r_co           <= r_co + CO_IDX_BW'(1);
                            r_state        <= S_ISSUE;
                            r_acc_in_valid <= 1'b1;
                        end
                    end else if (w_wd_fire) begin
                        r_wd_pulse     <= 1'b1;
                        r_err          <= 1'b1;
                        r_state        <= S_ISSUE;
                        r_acc_in_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (i_ot_ready) begin
                        r_ot_valid  <= 1'b0;
                        r_state     <= S_IDLE;
                        r_win_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_win_ready      = r_win_ready;
    assign o_w_sel          = r_co;
    assign o_acc_in_valid   = r_acc_in_valid;
    assign o_acc_soft_reset = i_soft_reset | r_wd_pulse;
    assign o_ot_valid       = r_ot_valid;
    assign o_ot_data        = r_buf;
    assign o_busy           = r_busy;
    assign o_err            = r_err;

endmodule

// File: tb/tb_cnn_acc_ci_sched.sv
// Directed testbench for cnn_acc_ci_sched (CO=3, ACC_BW=24, TIMEOUT=15).
// Inputs are driven 1 time unit after each rising edge. Outputs are
// sampled at that same point, away from the edge.
module tb_cnn_acc_ci_sched;

  localparam int CO      = 3;
  localparam int ACC_BW  = 24;
  localparam int IDX_BW  = 2;
  localparam int TIMEOUT = 15;
  localparam int DW      = CO * ACC_BW;

  logic              clk;
  logic              reset_n;
  logic              i_soft_reset;
  logic              i_win_valid;
  logic              o_win_ready;
  logic [IDX_BW-1:0] o_w_sel;
  logic              o_acc_in_valid;
  logic              o_acc_soft_reset;
  logic              i_acc_valid;
  logic [ACC_BW-1:0] i_acc_data;
  logic              i_ot_ready;
  logic              o_ot_valid;
  logic [DW-1:0]     o_ot_data;
  logic              o_busy;
  logic              o_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  cnn_acc_ci_sched #(
    .CO(CO), .ACC_BW(ACC_BW), .CO_IDX_BW(IDX_BW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(i_soft_reset),
    .i_win_valid(i_win_valid), .o_win_ready(o_win_ready),
    .o_w_sel(o_w_sel), .o_acc_in_valid(o_acc_in_valid),
    .o_acc_soft_reset(o_acc_soft_reset), .i_acc_valid(i_acc_valid),
    .i_acc_data(i_acc_data), .i_ot_ready(i_ot_ready),
    .o_ot_valid(o_ot_valid), .o_ot_data(o_ot_data),
    .o_busy(o_busy), .o_err(o_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pack3(input logic [ACC_BW-1:0] c2,
                                          input logic [ACC_BW-1:0] c1,
                                          input logic [ACC_BW-1:0] c0);
    return {c2, c1, c0};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Accept a window while IDLE. Afterwards the bench sits in the ISSUE
  // cycle of channel 0, and cyc counts from the accept cycle (cycle 0).
  task automatic accept_window();
    chk("win_ready_idle", o_win_ready, 1);
    i_win_valid = 1'b1;
    cyc = 0;
    tick();
    i_win_valid = 1'b0;
  endtask

  // Called in a channel's ISSUE cycle. Answers k cycles after the pulse.
  // The stray option drives a bogus result during the ISSUE cycle.
  task automatic do_channel(input int sel, input logic [ACC_BW-1:0] d,
                            input int k, input bit stray);
    chk("in_valid_pulse", o_acc_in_valid, 1);
    chk("w_sel_issue", o_w_sel, sel);
    if (stray) begin
      i_acc_valid = 1'b1;
      i_acc_data  = 24'hABC;
    end
    for (int i = 1; i < k; i++) begin
      tick();
      i_acc_valid = 1'b0;
      i_acc_data  = '0;
      chk("in_valid_low_wait", o_acc_in_valid, 0);
    end
    tick();
    chk("w_sel_wait", o_w_sel, sel);
    chk("in_valid_low_resp", o_acc_in_valid, 0);
    i_acc_valid = 1'b1;
    i_acc_data  = d;
    tick();
    i_acc_valid = 1'b0;
    i_acc_data  = '0;
    chk("no_wd_pulse", o_acc_soft_reset, 0);
  endtask

  task automatic handshake();
    i_ot_ready = 1'b1;
    tick();
    i_ot_ready = 1'b0;
    chk("idle_after_hs", o_busy, 0);
    chk("ot_valid_drop", o_ot_valid, 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    i_soft_reset = 1'b0;
    i_win_valid  = 1'b0;
    i_acc_valid  = 1'b0;
    i_acc_data   = '0;
    i_ot_ready   = 1'b0;
    #23;
    reset_n = 1'b1;
    tick();

    // reset state
    chk("rst_win_ready", o_win_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_ot_valid", o_ot_valid, 0);
    chk("rst_in_valid", o_acc_in_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ot_data", o_ot_data, 0);
    chk("rst_soft_out", o_acc_soft_reset, 0);

    // stray result in IDLE
    i_acc_valid = 1'b1;
    i_acc_data  = 24'hABC;
    tick();
    i_acc_valid = 1'b0;
    i_acc_data  = '0;
    chk("stray_idle_buf", o_ot_data, 0);
    chk("stray_idle_busy", o_busy, 0);

    // nominal window, k=2: pulses in cycles 1,4,7, result in cycle 10
    accept_window();
    chk("nom_cyc_ch0", cyc, 1);
    do_channel(0, 24'd100, 2, 1'b0);
    chk("nom_cyc_ch1", cyc, 4);
    do_channel(1, 24'd200, 2, 1'b0);
    chk("nom_cyc_ch2", cyc, 7);
    do_channel(2, 24'd300, 2, 1'b0);
    chk("nom_ot_valid", o_ot_valid, 1);
    chk("nom_ot_cycle", cyc, 10);
    chk("nom_ot_data", o_ot_data, pack3(24'd300, 24'd200, 24'd100));
    chk("nom_err", o_err, 0);

    // back-pressure: 5 cycles without ready, new window offered
    i_win_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ot_valid", o_ot_valid, 1);
      chk("bp_ot_data", o_ot_data, pack3(24'd300, 24'd200, 24'd100));
      chk("bp_win_ready", o_win_ready, 0);
    end
    // win_valid stays high through the handshake: no same-cycle pass-through
    handshake();
    chk("bp_win_ready_after", o_win_ready, 1);
    chk("bp_data_kept", o_ot_data, pack3(24'd300, 24'd200, 24'd100));
    i_win_valid = 1'b0;

    // k=1 window with a stray result in channel 1's ISSUE cycle
    accept_window();
    do_channel(0, 24'h11, 1, 1'b0);
    do_channel(1, 24'h22, 1, 1'b1);
    do_channel(2, 24'h33, 1, 1'b0);
    chk("k1_ot_cycle", cyc, 7);
    chk("k1_ot_data", o_ot_data, pack3(24'h33, 24'h22, 24'h11));
    handshake();

    // watchdog on channel 1
    accept_window();
    do_channel(0, 24'd5, 3, 1'b0);
    chk("wd_issue_pulse", o_acc_in_valid, 1);
    chk("wd_issue_sel", o_w_sel, 1);
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      chk("wd_wait_no_pulse", o_acc_soft_reset, 0);
      chk("wd_wait_no_issue", o_acc_in_valid, 0);
    end
    tick();
    chk("wd_soft_pulse", o_acc_soft_reset, 1);
    chk("wd_err_set", o_err, 1);
    chk("wd_slot0_kept", o_ot_data[ACC_BW-1:0], 24'd5);
    do_channel(1, 24'd66, 2, 1'b0);
    do_channel(2, 24'd77, 2, 1'b0);
    chk("wd_ot_data", o_ot_data, pack3(24'd77, 24'd66, 24'd5));
    chk("wd_err_sticky", o_err, 1);
    handshake();

    // soft reset in the middle of channel 2's WAIT
    accept_window();
    do_channel(0, 24'd7, 2, 1'b0);
    do_channel(1, 24'd8, 2, 1'b0);
    chk("sr_sel2", o_w_sel, 2);
    tick();
    tick();
    i_soft_reset = 1'b1;
    #1;
    chk("sr_soft_out_same", o_acc_soft_reset, 1);
    tick();
    i_soft_reset = 1'b0;
    #1;
    chk("sr_busy", o_busy, 0);
    chk("sr_err", o_err, 0);
    chk("sr_win_ready", o_win_ready, 1);
    chk("sr_ot_data", o_ot_data, 0);
    chk("sr_soft_out_drop", o_acc_soft_reset, 0);

    // fresh window; channel 0 answers on the watchdog's last cycle (capture wins)
    accept_window();
    do_channel(0, 24'hAAAAAA, TIMEOUT, 1'b0);
    chk("edge_err", o_err, 0);
    do_channel(1, 24'h000001, 1, 1'b0);
    do_channel(2, 24'h123456, 2, 1'b0);
    chk("edge_ot_cycle", cyc, 22);
    chk("edge_ot_data", o_ot_data, pack3(24'h123456, 24'h000001, 24'hAAAAAA));
    chk("edge_err_end", o_err, 0);
    handshake();

    // asynchronous reset during ISSUE
    accept_window();
    chk("ar_issue", o_acc_in_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_in_valid", o_acc_in_valid, 0);
    chk("ar_busy", o_busy, 0);
    chk("ar_win_ready", o_win_ready, 1);
    chk("ar_ot_data", o_ot_data, 0);
    chk("ar_ot_valid", o_ot_valid, 0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("ar_win_ready_rel", o_win_ready, 1);
    chk("ar_in_valid_rel", o_acc_in_valid, 0);
    chk("ar_sel_rel", o_w_sel, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // watchdog for the bench itself
  initial begin
    #200000;
    $display("FAIL bench_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/cnn_acc_ci_sched.md
Name: cnn_acc_ci_sched

Overview:
- Time-multiplexes one shared CI-accumulator datapath (CI parallel kernel MACs plus a CI-sum register) across CO output channels for each input window.
- Per accepted window, the block steps a weight-select index through every output channel, fires one datapath valid per channel and captures each channel sum.
- It presents all CO sums as one packed result with a valid/ready handshake.
- A watchdog recovers a hung datapath by pulsing its soft reset and retrying the current channel.

Parameters:
- CO, 3, number of output channels sequenced per window (>=1).
- ACC_BW, 24, width of one channel sum returned by the datapath.
- CO_IDX_BW, 2, width of channel index; must satisfy 2^CO_IDX_BW >= CO.
- TIMEOUT, 15, max cycles spent in WAIT before the watchdog fires (>=2).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_soft_reset  in  1  synchronous clear of all state, counters, buffer and error flag.
- i_win_valid  in  1  input window (fmap) valid; fmap held stable by upstream until the window is accepted and o_ot_valid handshakes.
- o_win_ready  out  1  high only in IDLE.
- o_w_sel  out  CO_IDX_BW  current output-channel index; selects the weight set fed to the datapath.
- o_acc_in_valid  out  1  one-cycle start pulse to the datapath.
- o_acc_soft_reset  out  1  datapath soft reset = i_soft_reset OR registered watchdog pulse.
- i_acc_valid  in  1  datapath result valid.
- i_acc_data  in  ACC_BW  datapath channel sum.
- i_ot_ready  in  1  downstream accepts the packed result.
- o_ot_valid  out  1  packed result valid; held until i_ot_ready.
- o_ot_data  out  CO*ACC_BW  channel c occupies bits [c*ACC_BW +: ACC_BW].
- o_busy  out  1  state != IDLE.
- o_err  out  1  sticky: at least one watchdog event since reset/soft reset.

Behaviour:
- Reset (reset_n low, or i_soft_reset high at a clock edge): state=IDLE, co index=0, watchdog count=0, buffer=0, o_err=0, o_ot_valid=0, o_acc_in_valid=0, o_busy=0. o_win_ready=1 after reset.
- i_soft_reset has priority over every other event in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - o_win_ready=1.
  - When i_win_valid=1, the window is accepted: co=0 and the next state is ISSUE.
- ISSUE:
  - o_acc_in_valid=1 for exactly this cycle and o_w_sel=co.
  - The watchdog count clears.
  - The next state is WAIT unconditionally.
  - i_acc_valid is ignored in this state.
- WAIT:
  - o_w_sel stays at co and the watchdog count increments each cycle.
  - When i_acc_valid=1, i_acc_data is written into buffer slot co.
    - If co==CO-1, the next state is OUT.
    - Otherwise co is incremented and the next state is ISSUE.
  - If the count reaches TIMEOUT without i_acc_valid:
    - o_acc_soft_reset pulses high in the next cycle, for 1 cycle.
    - o_err is set.
    - The next state is ISSUE with the same co (unlimited retries).
    - The stale slot is not written.
  - If i_acc_valid arrives in the same cycle as the count reaches TIMEOUT, the capture wins and the watchdog does not fire.
- OUT:
  - o_ot_valid=1 and o_ot_data=buffer, held stable.
  - When i_ot_ready=1, the result is consumed and the next state is IDLE.
  - The new window can be accepted one cycle after the handshake (no same-cycle pass-through).
- Stray i_acc_valid in IDLE, ISSUE or OUT is ignored and the buffer is unchanged.
- o_ot_data keeps the last result after the handshake until overwritten slot by slot.
- Timing: the datapath returns i_acc_valid k>=1 cycles after o_acc_in_valid.
  - Each channel costs k+1 cycles.
  - Take the accept cycle as 0; o_ot_valid first goes high in cycle CO*(k+1)+1.
- Widths: no arithmetic on the data path. The co counter never exceeds CO-1, and the watchdog counter saturates at TIMEOUT.
- reset_n asserted mid-operation: immediate asynchronous return to the reset values; no pulse is emitted on o_acc_in_valid.

Test Plan:
- Nominal, CO=3, k=2, datapath returns 100,200,300 per channel:
  - o_acc_in_valid pulses in cycles 1,4,7 with o_w_sel 0,1,2.
  - o_ot_valid rises in cycle 10 with o_ot_data={300,200,100}.
  - o_err=0.
- Back-pressure: hold i_ot_ready=0 for 5 cycles in OUT.
  - o_ot_valid and o_ot_data stay stable, o_win_ready=0 and new i_win_valid is not accepted.
  - Release i_ot_ready: IDLE the next cycle.
- Watchdog, TIMEOUT=15: suppress i_acc_valid for channel 1.
  - o_acc_soft_reset pulses once after 15 WAIT cycles and o_err=1.
  - o_acc_in_valid re-pulses with o_w_sel=1.
  - Normal completion follows, with slot0 intact.
- Stray results: assert i_acc_valid with data 0xABC in IDLE and during an ISSUE cycle.
  - No buffer change, and the final o_ot_data carries only WAIT-captured values.
- Soft reset mid-WAIT of channel 2:
  - Next cycle state=IDLE, o_busy=0, o_err=0 and o_acc_soft_reset=1 in the same cycle as i_soft_reset.
  - A fresh window restarts at o_w_sel=0.
- Async reset_n low in ISSUE:
  - o_acc_in_valid drops immediately, all outputs go to their reset values, and o_win_ready=1 after release.
